lsu_mem_ctrl: RTL
=================

# lsu_mem_ctrl

Load/store unit memory controller between the MEM pipeline stage and a handshaked data-memory port. Takes one load or store request at a time, drives word-aligned bus requests with byte enables and lane-shifted write data, waits for grant and response, then returns sign/zero-extended load data or a store acknowledge. Covers bus wait states and response timeout, and can split word-crossing misaligned accesses into two bus beats.

## Interface
- TIMEOUT_CYCLES, 255: max cycles from bus-request issue to mem_rvalid per beat; 0 disables timeout.
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- req_valid  in  1  pipeline request.
- req_ready  out  1  high only in IDLE; request accepted on req_valid && req_ready.
- req_we  in  1  1 = store, 0 = load.
- req_type  in  3  load: 000 LB, 001 LH, 010 LW, 011 LBU, 100 LHU; store uses [1:0]: 00 SB, 01 SH, 10 SW.
- req_addr  in  32  byte address.
- req_wdata  in  32  store data (rs2), right-aligned.
- resp_valid  out  1  one-cycle completion pulse.
- resp_rdata  out  32  extended load data; 0 for stores and errors.
- resp_err  out  1  qualified by resp_valid: misaligned (macro off), illegal type, or timeout.
- busy  out  1  high in any state other than IDLE.
- mem_req  out  1  bus request, held until mem_gnt.
- mem_we  out  1  bus write.
- mem_addr  out  32  word address, [1:0] always 00.
- mem_wdata  out  32  lane-positioned write data.
- mem_be  out  4  byte enables (bit i = byte lane i, little-endian).
- mem_gnt  in  1  request accepted this cycle.
- mem_rvalid  in  1  beat response (read data or write ack), at least 1 cycle after mem_gnt.
- mem_rdata  in  32  read data, valid with mem_rvalid.

## Operation
- States: IDLE, REQ1, WAIT1, REQ2, WAIT2, RESP.
- IDLE: on accept, latch we/type/addr/wdata; illegal type (load 101–111, store 11) or misaligned with macro off -> RESP with err, no bus activity; else -> REQ1.
- Size: byte 1, half 2, word 4; off = addr[1:0]; mask = ((1<<size)-1) << off as 8-bit value; shifted data = {32'b0, wdata} << 8*off as 64-bit value.
- REQ1: mem_addr = {addr[31:2],2'b00}, mem_be = mask[3:0], mem_wdata = shifted[31:0]; on mem_gnt -> WAIT1.
- WAIT1: on mem_rvalid latch rdata as beat0; -> REQ2 if mask[7:4] != 0, else RESP.
- REQ2/WAIT2: mem_addr = first word address + 4 (wraps mod 2^32, 0xFFFFFFFC -> 0x00000000), mem_be = mask[7:4], mem_wdata = shifted[63:32]; on mem_rvalid latch beat1 -> RESP.
- RESP: resp_valid = 1 for one cycle; load data = ({beat1, beat0} >> 8*off) truncated to size, sign-extended for LB/LH, zero-extended for LBU/LHU; -> IDLE.
- Misaligned: half with addr[0]=1, word with off != 0.
- Timeout: per-beat counter cleared on entering REQ1/REQ2, counts in REQx and WAITx; reaching TIMEOUT_CYCLES -> RESP with resp_err=1, mem_req dropped, remaining beat not issued.
- mem_rvalid ignored in IDLE, REQx and RESP. No resp backpressure.

## Timing
- Reset: all outputs 0 except req_ready = 1; state IDLE; counter and latches 0. Reset mid-access aborts immediately with no response; a late mem_rvalid after reset is ignored.
- Accept at cycle N -> mem_req high N+1. Gnt at G -> WAIT from G+1. rvalid at R -> resp_valid at R+1 (single beat) or mem_req for beat 2 at R+1.
- Best case single beat: gnt in N+1, rvalid N+2, resp_valid N+3. Error without bus: resp_valid N+1.
- mem_* outputs registered and stable while mem_req high and mem_gnt low.
- req_ready low from N+1 through the RESP cycle; next accept earliest the cycle after RESP.

## Configuration
- LSU_MISALIGN_SPLIT_EN defined: misaligned accesses execute; within-word misaligned (e.g. LH off 1) use one beat, word-crossing use two beats as above.
- Undefined: REQ2/WAIT2 unreachable; any misaligned access returns resp_err=1, resp_rdata=0 in one cycle with no bus request.

## Test plan
- LW 0x100, gnt same cycle, rvalid next, rdata 0x8899AABB -> resp_valid at N+3, rdata 0x8899AABB, be 1111, err 0.
- LB 0x103 rdata 0x80112233 -> 0xFFFFFF80; LBU same -> 0x00000080; SH 0x102 wdata 0x1234 -> be 1100, wdata 0x12340000.
- Macro on, LW 0x1FE, beats 0xAABBCCDD then 0x11223344 -> addrs 0x1FC/0x200, be 1100/0011, rdata 0x3344AABB.
- Macro on, SW 0xFFFFFFFF wdata 0xDEADBEEF -> beat1 addr 0xFFFFFFFC be 1000 wdata 0xEF000000, beat2 addr 0x00000000 be 0111 wdata 0x00DEADBE.
- TIMEOUT_CYCLES=4, gnt never asserted -> mem_req drops after 4 cycles, resp_valid with err=1, rdata 0; macro off, LH 0x101 -> err=1 at N+1, no mem_req.
- rst_n low during WAIT1 then rvalid pulse after release -> no resp_valid, req_ready 1, next LW completes normally.

Source files
------------

// File: rtl/lsu_mem_ctrl.sv
// -----------------------------------------------------------------------------
// lsu_mem_ctrl
//
// Load/store unit memory controller sitting between the MEM pipeline stage and
// a handshaked data-memory port. One request is in flight at a time. The unit
// issues word-aligned bus beats with byte enables and lane-positioned write
// data. Loads return sign/zero-extended data; stores return an acknowledge.
// A per-beat timeout aborts a stalled beat.
//
// Build option:
//   LSU_MISALIGN_SPLIT_EN  defined   -> misaligned accesses execute; accesses
//                                       that cross a word boundary use two
//                                       bus beats (REQ2/WAIT2).
//                          undefined -> misaligned accesses complete at once
//                                       with resp_err=1 and no bus activity.
//
// Parameters:
//   TIMEOUT_CYCLES  max cycles per beat from bus request to mem_rvalid
//                   (0 disables the timeout).
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   req_valid/ready   pipeline request handshake (ready only in IDLE)
//   req_we/type/addr/wdata  request fields (wdata right-aligned)
//   resp_valid        one-cycle completion pulse (no backpressure)
//   resp_rdata        extended load data, 0 for stores and errors
//   resp_err          illegal type, misaligned (option off) or timeout
//   busy              high whenever not IDLE
//   mem_req/we/addr/wdata/be  bus request, held until mem_gnt
//   mem_gnt           bus accepted the request this cycle
//   mem_rvalid/rdata  beat response, at least one cycle after mem_gnt
//   dbg_state         current FSM state encoding
//
// Handshakes: a transfer happens on a cycle where valid and ready/gnt are both
// high. req_valid is only observed in IDLE; mem_req with its address, byte
// enables and data stays stable until the cycle mem_gnt is seen; mem_rvalid
// is only observed in WAIT1/WAIT2.
// -----------------------------------------------------------------------------
module lsu_mem_ctrl #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic        req_we,
  input  logic [2:0]  req_type,
  input  logic [31:0] req_addr,
  input  logic [31:0] req_wdata,
  output logic        resp_valid,
  output logic [31:0] resp_rdata,
  output logic        resp_err,
  output logic        busy,
  output logic        mem_req,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_be,
  input  logic        mem_gnt,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic [2:0]  dbg_state
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_REQ1  = 3'd1,
    S_WAIT1 = 3'd2,
    S_REQ2  = 3'd3,
    S_WAIT2 = 3'd4,
    S_RESP  = 3'd5
  } state_t;

  state_t      state, state_nxt;

  logic        lat_we;
  logic [2:0]  lat_type;
  logic [31:0] lat_addr;
  logic [31:0] lat_wdata;
  logic        lat_err;
  logic [31:0] beat0, beat1;
  logic [31:0] tcnt;

  logic [2:0]  in_size;
  logic        in_err;
  logic [2:0]  l_size;
  logic [7:0]  l_lanes;
  logic [7:0]  l_mask;
  logic [63:0] l_shift;
  logic [31:0] word0;
  logic [31:0] ld_word;
  logic [31:0] ld_ext;
  logic        tmo_hit;
  logic        tmo_abort;

  // Access size in bytes, 0 for an illegal type. Stores only decode [1:0].
  function automatic logic [2:0] size_of(input logic we, input logic [2:0] t);
    logic [2:0] s;
    s = 3'd0;
    if (we) begin
      case (t[1:0])
        2'b00:   s = 3'd1;
        2'b01:   s = 3'd2;
        2'b10:   s = 3'd4;
        default: s = 3'd0;
      endcase
    end else begin
      case (t)
        3'b000, 3'b011: s = 3'd1;
        3'b001, 3'b100: s = 3'd2;
        3'b010:         s = 3'd4;
        default:        s = 3'd0;
      endcase
    end
    return s;
  endfunction

  // Decode of the incoming request, used only at accept time.
  always_comb begin
    in_size = size_of(req_we, req_type);
`ifdef LSU_MISALIGN_SPLIT_EN
    in_err  = (in_size == 3'd0);
`else
    in_err  = (in_size == 3'd0) ||
              ((in_size == 3'd2) && req_addr[0]) ||
              ((in_size == 3'd4) && (req_addr[1:0] != 2'b00));
`endif
  end

  // Lane mask and write data for both beats. mask[7:4] non-zero means the
  // access spills into the next word.
  always_comb begin
    l_size  = size_of(lat_we, lat_type);
    l_lanes = (l_size == 3'd1) ? 8'h01 : (l_size == 3'd2) ? 8'h03 : 8'h0F;
    l_mask  = l_lanes << lat_addr[1:0];
    l_shift = {32'b0, lat_wdata} << {lat_addr[1:0], 3'b000};
    word0   = {lat_addr[31:2], 2'b00};
  end

  // Load data realignment and extension.
  always_comb begin
    ld_word = 32'({beat1, beat0} >> {lat_addr[1:0], 3'b000});
    case (lat_type)
      3'b000:  ld_ext = {{24{ld_word[7]}}, ld_word[7:0]};
      3'b001:  ld_ext = {{16{ld_word[15]}}, ld_word[15:0]};
      3'b011:  ld_ext = {24'b0, ld_word[7:0]};
      3'b100:  ld_ext = {16'b0, ld_word[15:0]};
      default: ld_ext = ld_word;
    endcase
  end

  // Next-state logic. A grant or response in the same cycle the timeout is
  // reached still counts as progress; the >= keeps the count effective after
  // a late grant moves the beat into its WAIT state.
  always_comb begin
    state_nxt = state;
    tmo_abort = 1'b0;
    tmo_hit   = (TIMEOUT_CYCLES != 0) && (tcnt >= (TIMEOUT_CYCLES - 32'd1));
    case (state)
      S_IDLE: begin
        if (req_valid) state_nxt = in_err ? S_RESP : S_REQ1;
      end
      S_REQ1: begin
        if (mem_gnt) state_nxt = S_WAIT1;
        else if (tmo_hit) begin
          state_nxt = S_RESP;
          tmo_abort = 1'b1;
        end
      end
      S_WAIT1: begin
        if (mem_rvalid) begin
`ifdef LSU_MISALIGN_SPLIT_EN
          state_nxt = (l_mask[7:4] != 4'b0000) ? S_REQ2 : S_RESP;
`else
          state_nxt = S_RESP;
`endif
        end else if (tmo_hit) begin
          state_nxt = S_RESP;
          tmo_abort = 1'b1;
        end
      end
      S_REQ2: begin
        if (mem_gnt) state_nxt = S_WAIT2;
        else if (tmo_hit) begin
          state_nxt = S_RESP;
          tmo_abort = 1'b1;
        end
      end
      S_WAIT2: begin
        if (mem_rvalid) state_nxt = S_RESP;
        else if (tmo_hit) begin
          state_nxt = S_RESP;
          tmo_abort = 1'b1;
        end
      end
      S_RESP:  state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_we    <= 1'b0;
      lat_type  <= 3'b000;
      lat_addr  <= 32'b0;
      lat_wdata <= 32'b0;
      lat_err   <= 1'b0;
      beat0     <= 32'b0;
      beat1     <= 32'b0;
    end else begin
      if (state == S_IDLE && req_valid) begin
        lat_we    <= req_we;
        lat_type  <= req_type;
        lat_addr  <= req_addr;
        lat_wdata <= req_wdata;
        lat_err   <= in_err;
        beat0     <= 32'b0;
        beat1     <= 32'b0;
      end
      if (state == S_WAIT1 && mem_rvalid) beat0 <= mem_rdata;
      if (state == S_WAIT2 && mem_rvalid) beat1 <= mem_rdata;
      if (tmo_abort) lat_err <= 1'b1;
    end
  end

  // Per-beat timeout counter: restarts on entry to each REQ state and runs
  // through the matching WAIT state.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      tcnt <= 32'b0;
    end else if ((state_nxt == S_REQ1 && state != S_REQ1) ||
                 (state_nxt == S_REQ2 && state != S_REQ2)) begin
      tcnt <= 32'b0;
    end else if (state == S_REQ1 || state == S_WAIT1 ||
                 state == S_REQ2 || state == S_WAIT2) begin
      tcnt <= tcnt + 32'd1;
    end else begin
      tcnt <= 32'b0;
    end
  end

  // Outputs decode registered state and latches only.
  always_comb begin
    req_ready  = (state == S_IDLE);
    busy       = (state != S_IDLE);
    resp_valid = (state == S_RESP);
    resp_err   = (state == S_RESP) && lat_err;
    resp_rdata = ((state == S_RESP) && !lat_we && !lat_err) ? ld_ext : 32'b0;
    mem_req    = (state == S_REQ1) || (state == S_REQ2);
    mem_we     = mem_req && lat_we;
    mem_addr   = 32'b0;
    mem_be     = 4'b0000;
    mem_wdata  = 32'b0;
    if (state == S_REQ1) begin
      mem_addr  = word0;
      mem_be    = l_mask[3:0];
      mem_wdata = l_shift[31:0];
    end else if (state == S_REQ2) begin
      mem_addr  = word0 + 32'd4;
      mem_be    = l_mask[7:4];
      mem_wdata = l_shift[63:32];
    end
    dbg_state  = state;
  end

endmodule
